// File: rtl/cpu_pkg.sv
// cpu_pkg: shared controller states, ISA constants and datapath select encodings
package cpu_pkg;
  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_GET_A,
    S_GET_B,
    S_ALU,
    S_CMP,
    S_WR_REG,
    S_WR_IMM
  } state_t;
  typedef enum logic [2:0] {
    CLS_MOV_IMM,
    CLS_MOV_REG,
    CLS_ALU2,
    CLS_CMP,
    CLS_UNDEF
  } cls_t;
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_CMP = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MVN = 2'b11;
  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RN = 3'b001;
  localparam logic [2:0] NSEL_RD = 3'b010;
  localparam logic [2:0] NSEL_RM = 3'b100;
  localparam logic [3:0] VSEL_NONE = 4'b0000;
  localparam logic [3:0] VSEL_C = 4'b0001;
  localparam logic [3:0] VSEL_IMM = 4'b0100;
endpackage

// File: rtl/fsm_decode.sv
// fsm_decode: classifies the latched {opcode, op} into an instruction class
module fsm_decode
  import cpu_pkg::*;
(
  input  logic [4:0] ir,
  output cls_t       cls
);
  // ALU ops other than CMP share one sequence, so they collapse into one class
  always_comb
    cls = ir == {OPC_MOV, OP_MOV_IMM} ? CLS_MOV_IMM :
          ir == {OPC_MOV, OP_MOV_REG} ? CLS_MOV_REG :
          ir == {OPC_ALU, OP_CMP}     ? CLS_CMP     :
          ir[4:2] == OPC_ALU          ? CLS_ALU2    : CLS_UNDEF;
endmodule

// File: rtl/cpu_fsm.sv
// cpu_fsm: sequences datapath control strobes for MOV and ALU instructions
module cpu_fsm
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic [2:0] nsel,
  output logic [3:0] vsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic       write
);
  state_t     state;
  cls_t       cls;
  logic [4:0] ir;
  logic       la_q, lb_q, lc_q, ls_q, wr_q;
  fsm_decode u_dec (.ir(ir), .cls(cls));
  assign bsel = 1'b0;
  // reset kills every commit strobe in the very cycle it is sampled
  assign {loada, loadb, loadc, loads, write} = {la_q, lb_q, lc_q, ls_q, wr_q} & {5{~reset}};
  // state register with outputs registered for the state being entered
  always_ff @(posedge clk)
    if (reset) begin
      state <= S_WAIT;
      ir <= '0;
      w <= 1'b1;
      nsel <= NSEL_NONE;
      vsel <= VSEL_NONE;
      asel <= 1'b0;
      {la_q, lb_q, lc_q, ls_q, wr_q} <= '0;
    end else begin
      w <= 1'b0;
      nsel <= NSEL_NONE;
      vsel <= VSEL_NONE;
      asel <= 1'b0;
      {la_q, lb_q, lc_q, ls_q, wr_q} <= '0;
      case (state)
        S_WAIT:
          if (s) begin
            ir <= {opcode, op};
            state <= S_DECODE;
          end else w <= 1'b1;
        S_DECODE:
          case (cls)
            CLS_MOV_IMM: begin
              state <= S_WR_IMM;
              nsel <= NSEL_RN;
              vsel <= VSEL_IMM;
              wr_q <= 1'b1;
            end
            CLS_MOV_REG: begin
              state <= S_GET_B;
              nsel <= NSEL_RM;
              lb_q <= 1'b1;
            end
            CLS_ALU2, CLS_CMP: begin
              state <= S_GET_A;
              nsel <= NSEL_RN;
              la_q <= 1'b1;
            end
            default: begin
              state <= S_WAIT;
              w <= 1'b1;
            end
          endcase
        S_GET_A: begin
          state <= S_GET_B;
          nsel <= NSEL_RM;
          lb_q <= 1'b1;
        end
        S_GET_B:
          if (cls == CLS_CMP) begin
            state <= S_CMP;
            ls_q <= 1'b1;
          end else begin
            state <= S_ALU;
            lc_q <= 1'b1;
            asel <= cls == CLS_MOV_REG;
          end
        S_ALU: begin
          state <= S_WR_REG;
          nsel <= NSEL_RD;
          vsel <= VSEL_C;
          wr_q <= 1'b1;
        end
        default: begin
          state <= S_WAIT;
          w <= 1'b1;
        end
      endcase
    end
endmodule

// File: tb/tb_cpu_fsm.sv
// tb_cpu_fsm: randomized and directed checks of cpu_fsm against a per-instruction strobe-sequence model
module tb_cpu_fsm;
  logic       clk = 1'b0;
  logic       reset, s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       w, loada, loadb, loadc, loads, asel, bsel, write;
  logic [2:0] nsel;
  logic [3:0] vsel;
  logic [14:0] outv;
  logic [14:0] q[$];
  int checks = 0;
  int errors = 0;
  cpu_fsm dut (
    .clk(clk), .reset(reset), .s(s), .opcode(opcode), .op(op),
    .w(w), .nsel(nsel), .vsel(vsel), .loada(loada), .loadb(loadb),
    .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel), .write(write)
  );
  always #5 clk = ~clk;
  assign outv = {w, nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write};
  function automatic logic [14:0] mk(logic wi, logic [2:0] n, logic [3:0] v, logic [3:0] ld, logic a, logic wr);
    return {wi, n, v, ld, a, 1'b0, wr};
  endfunction
  localparam logic [14:0] IDLE = 15'b1_000_0000_0000_0_0_0;
  task automatic chk(input string tag, input logic [14:0] got, input logic [14:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b expected=%b at %0t", tag, got, exp, $time);
    end
  endtask
  // expected per-cycle outputs from the decode cycle until the return to idle
  task automatic build(input logic [2:0] oc, input logic [1:0] o);
    bit mov_imm = oc == 3'b110 && o == 2'b10;
    bit mov_reg = oc == 3'b110 && o == 2'b00;
    bit is_alu  = oc == 3'b101;
    bit is_cmp  = is_alu && o == 2'b01;
    q.push_back(15'd0);
    if (mov_imm) q.push_back(mk(0, 3'b001, 4'b0100, 4'b0000, 0, 1));
    else if (mov_reg || is_alu) begin
      if (is_alu) q.push_back(mk(0, 3'b001, 4'b0000, 4'b1000, 0, 0));
      q.push_back(mk(0, 3'b100, 4'b0000, 4'b0100, 0, 0));
      if (is_cmp) q.push_back(mk(0, 3'b000, 4'b0000, 4'b0001, 0, 0));
      else begin
        q.push_back(mk(0, 3'b000, 4'b0000, 4'b0010, mov_reg, 0));
        q.push_back(mk(0, 3'b010, 4'b0001, 4'b0000, 0, 1));
      end
    end
  endtask
  task automatic cycle(input logic si, input logic [2:0] oi, input logic [1:0] pi, input string tag);
    logic idle;
    logic [14:0] e;
    s = si;
    opcode = oi;
    op = pi;
    idle = q.size() == 0;
    if (idle) e = IDLE;
    else e = q.pop_front();
    chk(tag, outv, e);
    if (idle && si) build(oi, pi);
    @(posedge clk);
    #1;
  endtask
  task automatic run_instr(input logic [2:0] oc, input logic [1:0] o, input string tag);
    cycle(1'b1, oc, o, tag);
    while (q.size() != 0) cycle(1'(($urandom)), 3'($urandom), 2'($urandom), tag);
    cycle(1'b0, oc, o, tag);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    logic [2:0] roc;
    reset = 1'b1;
    s = 1'b0;
    opcode = '0;
    op = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", outv, IDLE);
    reset = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("idle", outv, IDLE);
    end
    run_instr(3'b110, 2'b10, "mov_imm");
    run_instr(3'b110, 2'b00, "mov_reg");
    run_instr(3'b101, 2'b00, "add");
    run_instr(3'b101, 2'b01, "cmp");
    run_instr(3'b101, 2'b10, "and");
    run_instr(3'b101, 2'b11, "mvn");
    run_instr(3'b000, 2'b00, "undef");
    run_instr(3'b110, 2'b01, "undef_mov");
    cycle(1'b1, 3'b101, 2'b00, "rst_add");
    repeat (4) cycle(1'b0, 3'b000, 2'b00, "rst_add");
    reset = 1'b1;
    #1;
    chk("rst_wr_reg", outv, mk(0, 3'b010, 4'b0001, 4'b0000, 0, 0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    chk("rst_wait", outv, IDLE);
    repeat (600) begin
      case ($urandom % 4)
        0: roc = 3'b110;
        1: roc = 3'b101;
        default: roc = 3'($urandom);
      endcase
      cycle(1'(($urandom % 3) != 0), roc, 2'($urandom), "rand");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
